axis_pkt_mux: RTL
=================

Name: axis_pkt_mux

Overview:
- Parametrised N-to-1 AXI-Stream multiplexer; successor to the 2-input byte mux.
- Arbitrates per packet: once a channel is granted, it holds the output until its TLAST beat is accepted. Mid-packet interleaving never occurs.
- Grant comes from an external select (SEL mode) or an internal round-robin arbiter (RR mode).
- Output is fully registered through a 2-entry skid buffer, giving full throughput and no combinational ready path from m_axis_ready to s_axis_ready.

Parameters:
- NUM_CH, 4, number of slave channels (2..16).
- DATA_W, 8, TDATA width in bits.
- ARB_MODE, 0, 0 = SEL mode (grant from sel port), 1 = RR mode (round-robin, sel ignored).
- SEL_W, derived localparam = max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- s_axis_data  in  NUM_CH*DATA_W  slave TDATA; channel i occupies bits [i*DATA_W +: DATA_W].
- s_axis_valid  in  NUM_CH  slave TVALID per channel.
- s_axis_ready  out  NUM_CH  slave TREADY per channel.
- s_axis_last  in  NUM_CH  slave TLAST per channel.
- m_axis_data  out  DATA_W  master TDATA.
- m_axis_valid  out  1  master TVALID.
- m_axis_ready  in  1  master TREADY.
- m_axis_last  out  1  master TLAST.
- sel  in  SEL_W  requested channel (SEL mode only).
- active_ch  out  SEL_W  currently granted channel.
- busy  out  1  high while a packet is locked (state LOCKED).

Behaviour:
- Reset (async assert, sync deassert): outputs are driven as follows.
  - s_axis_ready = 0, m_axis_valid = 0, m_axis_data = 0, m_axis_last = 0.
  - active_ch = 0, busy = 0.
  - FSM = IDLE, skid buffer empty, RR pointer = NUM_CH-1 (so channel 0 wins first).
- FSM has two states, IDLE and LOCKED.
- IDLE:
  - All s_axis_ready = 0.
  - SEL mode: if s_axis_valid[sel] = 1, latch grant = sel and go to LOCKED next cycle.
  - RR mode: grant = first channel with valid = 1, searching from (pointer+1) mod NUM_CH upward with wrap. Latch it and go to LOCKED.
  - No valid requester: stay in IDLE.
  - sel >= NUM_CH: treated as no request.
- LOCKED:
  - s_axis_ready[grant] = skid buffer not full (registered signal). All other ready bits = 0.
  - A beat is accepted on valid & ready of the granted channel and written into the skid buffer.
  - When an accepted beat has last = 1: go to IDLE next cycle and, in RR mode, set pointer = grant.
  - sel changes while LOCKED are ignored.
- Arbitration bubble: one dead cycle (IDLE) between packets. Back-to-back packets therefore cost one cycle of input-side gap. The output side may stay continuous while the buffer drains.
- Latency: an accepted beat appears on m_axis_* on the next cycle when the buffer was empty.
- Throughput: 1 beat/cycle sustained while m_axis_ready = 1.
- Skid buffer:
  - 2 entries, FIFO order.
  - Output holds stable while m_axis_valid = 1 and m_axis_ready = 0 (AXI rule: data and last must not change until accepted).
  - Full means 2 entries held. Simultaneous push and pop when full is not possible, because ready was 0. Simultaneous push and pop with 1 entry keeps the count at 1.
- active_ch reflects the latched grant; it holds its last value in IDLE.
- busy = (state == LOCKED).
- Single-beat packet (valid & last on the first beat): LOCKED lasts 1 cycle if the buffer accepts immediately.
- Reset asserted mid-packet: the packet is dropped, the buffer is cleared and all outputs return to reset values immediately. No partial-beat recovery.
- Granted source deasserting valid mid-packet is legal. The mux stays LOCKED and waits.

Decomposition:
- Package axis_mux_pkg:
  - ARB_SEL = 0, ARB_RR = 1 constants.
  - FSM state encoding IDLE/LOCKED.
  - Function for max(1, clog2(n)).
- Sub-module axis_skid_reg (parameter DATA_W+1 wide payload: data plus last).
  - 2-entry registered skid buffer.
  - Exports in_ready, out_valid, out_payload.
  - Reusable by other stream blocks.
- Arbiter and FSM stay in the top level.

Test Plan:
- SEL mode, NUM_CH=4, sel=2, ch2 sends 4-beat packet 0x10..0x13 with last on 0x13, m_axis_ready=1:
  - m_axis shows 0x10..0x13 on consecutive cycles, the first one cycle after acceptance, last on 0x13.
  - s_axis_ready[0,1,3] stay 0 throughout.
- SEL mode, sel switched 2->1 after beat 2 of a ch2 packet, ch1 valid:
  - ch2 packet completes uninterrupted.
  - One IDLE cycle follows, then ch1 is granted and active_ch = 1.
- RR mode, all 4 channels continuously valid with 2-beat packets:
  - Grant order 0,1,2,3,0; each packet is contiguous on the output; busy drops for exactly one cycle between packets.
- Backpressure: m_axis_ready held 0 for 5 cycles mid-packet:
  - The buffer fills to 2 and s_axis_ready[grant] = 0.
  - m_axis_data/last stay stable; on release there is no loss or duplication of beats 0xA0..0xA5.
- Single-beat packets: ch3 sends 0x55 with last=1 repeatedly in RR mode alone:
  - One beat every 2 input cycles, each with m_axis_last = 1.
- Reset: reset_n pulsed low during beat 3 of a 6-beat packet:
  - All outputs are 0 within the same cycle, state IDLE, buffer empty.
  - After release, channel 0 has first RR priority.

Source files
------------

// File: rtl/axis_pkt_mux_pkg.sv
// Shared arbitration constants, FSM encoding and width helper for the packet mux.
package axis_mux_pkg;

  localparam int unsigned ARB_SEL = 0;
  localparam int unsigned ARB_RR  = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // max(1, clog2(n)) so a 2-channel mux still gets a 1-bit select
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/axis_pkt_mux_if.sv
// Stream bundle for the packet mux: NUM_CH slave channels plus one master channel.
interface axis_pkt_mux_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8
) ();

  logic [NUM_CH*DATA_W-1:0] s_axis_data;
  logic [NUM_CH-1:0]        s_axis_valid;
  logic [NUM_CH-1:0]        s_axis_ready;
  logic [NUM_CH-1:0]        s_axis_last;
  logic [DATA_W-1:0]        m_axis_data;
  logic                     m_axis_valid;
  logic                     m_axis_ready;
  logic                     m_axis_last;

  // master: the environment that sources the slave channels and sinks the output
  modport master (
    output s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
    input  s_axis_ready, m_axis_data, m_axis_valid, m_axis_last
  );

  // slave: the mux itself
  modport slave (
    input  s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
    output s_axis_ready, m_axis_data, m_axis_valid, m_axis_last
  );

endinterface

// File: rtl/axis_skid_reg.sv
// Two-entry registered skid buffer; in_ready comes straight from a flop.
module axis_skid_reg #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         ready_q;
  logic         push;
  logic         pop;

  assign push        = in_valid & ready_q;
  assign pop         = out_valid & out_ready;
  assign out_valid   = (count_q != 2'd0);
  assign out_payload = head_q;
  assign in_ready    = ready_q;

  // head is always the oldest entry; a push while full cannot occur
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_payload;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_payload;
        end else if (push) begin
          tail_d  = in_payload;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= (count_d != 2'd2);
    end
  end

endmodule

// File: rtl/axis_pkt_mux.sv
// N-to-1 AXI-Stream mux with per-packet arbitration (external select or round-robin).
module axis_pkt_mux
  import axis_mux_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ARB_MODE = ARB_SEL,
  localparam int unsigned SEL_W   = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  axis_pkt_mux_if.slave     bus,
  input  logic [SEL_W-1:0]  sel,
  output logic [SEL_W-1:0]  active_ch,
  output logic              busy
);

  localparam int unsigned PAY_W = DATA_W + 1;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              req_found;
  logic [SEL_W-1:0]  req_ch;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [NUM_CH-1:0] ready_vec;
  logic              skid_ready;
  logic              beat_acc;
  logic              out_valid;
  logic [PAY_W-1:0]  in_payload;
  logic [PAY_W-1:0]  out_payload;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_data[g] = bus.s_axis_data[g*DATA_W +: DATA_W];
  end

  // Requester picked while IDLE; RR scans upward from the slot after the last winner
  always_comb begin
    logic [SEL_W-1:0] cand;
    req_found = 1'b0;
    req_ch    = '0;
    cand      = '0;
    if (ARB_MODE == ARB_RR) begin
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
        cand = SEL_W'((32'(ptr_q) + i) % NUM_CH);
        if (!req_found && bus.s_axis_valid[cand]) begin
          req_found = 1'b1;
          req_ch    = cand;
        end
      end
    end else if ((32'(sel) < NUM_CH) && bus.s_axis_valid[sel]) begin
      req_found = 1'b1;
      req_ch    = sel;
    end
  end

  assign beat_acc   = (state_q == ST_LOCKED) && bus.s_axis_valid[grant_q] && skid_ready;
  assign in_payload = {bus.s_axis_last[grant_q], ch_data[grant_q]};

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          grant_d = req_ch;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (beat_acc && bus.s_axis_last[grant_q]) begin
          state_d = ST_IDLE;
          if (ARB_MODE == ARB_RR) ptr_d = grant_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= SEL_W'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    ready_vec = '0;
    if (state_q == ST_LOCKED) ready_vec[grant_q] = skid_ready;
  end

  axis_skid_reg #(.W(PAY_W)) u_skid (
    .clk         (clk),
    .rst_n       (reset_n),
    .in_valid    (beat_acc),
    .in_ready    (skid_ready),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (bus.m_axis_ready),
    .out_payload (out_payload)
  );

  assign bus.s_axis_ready = ready_vec;
  assign bus.m_axis_valid = out_valid;
  assign bus.m_axis_data  = out_payload[DATA_W-1:0];
  assign bus.m_axis_last  = out_payload[DATA_W];
  assign active_ch        = grant_q;
  assign busy             = (state_q == ST_LOCKED);

endmodule
